// File: rtl/pixel_write_sequencer_pkg.sv
// Shared panel defaults, sequencer state encoding and framebuffer address-width helper
// for the HUB75 pixel write path.
package pixel_write_sequencer_pkg;

    localparam int DEF_BITS_PER_PIXEL = 32;
    localparam int DEF_PANEL_WIDTH    = 64;
    localparam int DEF_PANEL_HEIGHT   = 32;

    typedef enum logic [0:0] {
        ST_FILL      = 1'b0,
        ST_WAIT_SWAP = 1'b1
    } seq_state_e;

    // One bank-select bit above the {y,x} pixel index.
    function automatic int fb_addr_w(input int width, input int height);
        return 1 + $clog2(width * height);
    endfunction

endpackage

// File: rtl/pixel_write_sequencer_pulse_sync.sv
// pulse_sync: two-flop synchroniser plus rising-edge detector for slow strobes
// crossing from the spi_clk domain; emits a single-cycle pulse per rising edge.
module pulse_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic pulse_o
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], async_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    // sync_q[1] is the metastability-filtered level, sync_q[2] its previous value.
    assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/pixel_write_sequencer.sv
// Bridges spi_slave pixel words into the double-buffered framebuffer and swaps banks at
// the scanner frame boundary. Optional statistics: define PIXEL_WRITE_SEQ_STATS_EN.
module pixel_write_sequencer
    import pixel_write_sequencer_pkg::*;
#(
    parameter int BITS_PER_PIXEL = DEF_BITS_PER_PIXEL,
    parameter int PANEL_WIDTH    = DEF_PANEL_WIDTH,
    parameter int PANEL_HEIGHT   = DEF_PANEL_HEIGHT,
    localparam int ADDR_W        = fb_addr_w(PANEL_WIDTH, PANEL_HEIGHT)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [BITS_PER_PIXEL-1:0] spi_data,
    input  logic                      spi_pixel_clk,
    input  logic                      resync,
    input  logic                      scan_frame_end,
    output logic                      fb_we,
    output logic [ADDR_W-1:0]         fb_waddr,
    output logic [BITS_PER_PIXEL-1:0] fb_wdata,
    output logic                      display_bank,
    output logic                      swap_pending,
    output logic                      overflow,
    output logic [15:0]               drop_count,
    output logic [15:0]               frame_count
);

    localparam int XW = $clog2(PANEL_WIDTH);
    localparam int YW = $clog2(PANEL_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(PANEL_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(PANEL_HEIGHT - 1);

    logic                      word_evt_s;
    seq_state_e                state_q, state_d;
    logic [XW-1:0]             x_q, x_d;
    logic [YW-1:0]             y_q, y_d;
    logic                      fb_we_q, fb_we_d;
    logic [ADDR_W-1:0]         fb_waddr_q, fb_waddr_d;
    logic [BITS_PER_PIXEL-1:0] fb_wdata_q, fb_wdata_d;
    logic                      bank_q, bank_d;
    logic                      pend_q, pend_d;
    logic                      ovf_q, ovf_d;

    pulse_sync u_strobe_sync (
        .clk      (clk),
        .rst_n    (reset_n),
        .async_in (spi_pixel_clk),
        .pulse_o  (word_evt_s)
    );

    // Raster walk, write issue and bank hand-off; resync outranks any word event.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        fb_we_d    = 1'b0;
        fb_waddr_d = fb_waddr_q;
        fb_wdata_d = fb_wdata_q;
        bank_d     = bank_q;
        pend_d     = pend_q;
        ovf_d      = ovf_q;

        if (resync) begin
            x_d = {XW{1'b0}};
            y_d = {YW{1'b0}};
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (word_evt_s) begin
                        fb_we_d    = 1'b1;
                        fb_waddr_d = {~bank_q, y_q, x_q};
                        fb_wdata_d = spi_data;
                        if (x_q == X_LAST) begin
                            x_d = {XW{1'b0}};
                            if (y_q == Y_LAST) begin
                                y_d     = {YW{1'b0}};
                                pend_d  = 1'b1;
                                state_d = ST_WAIT_SWAP;
                            end else begin
                                y_d = y_q + YW'(1);
                            end
                        end else begin
                            x_d = x_q + XW'(1);
                        end
                    end else begin
                        fb_we_d = 1'b0;
                    end
                end
                ST_WAIT_SWAP: begin
                    if (word_evt_s) begin
                        ovf_d = 1'b1;
                    end else begin
                        ovf_d = ovf_q;
                    end
                end
                default: begin
                    state_d = ST_FILL;
                end
            endcase
        end

        // A swap only happens from a settled WAIT_SWAP, so a last-pixel write never swaps itself.
        if ((state_q == ST_WAIT_SWAP) && scan_frame_end) begin
            bank_d  = ~bank_q;
            pend_d  = 1'b0;
            state_d = ST_FILL;
        end else begin
            bank_d = bank_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_FILL;
            x_q        <= {XW{1'b0}};
            y_q        <= {YW{1'b0}};
            fb_we_q    <= 1'b0;
            fb_waddr_q <= {ADDR_W{1'b0}};
            fb_wdata_q <= {BITS_PER_PIXEL{1'b0}};
            bank_q     <= 1'b0;
            pend_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            fb_we_q    <= fb_we_d;
            fb_waddr_q <= fb_waddr_d;
            fb_wdata_q <= fb_wdata_d;
            bank_q     <= bank_d;
            pend_q     <= pend_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef PIXEL_WRITE_SEQ_STATS_EN
    logic [15:0] drop_q, drop_d;
    logic [15:0] frame_q, frame_d;

    // Drops saturate so a long stall cannot alias to a small count; frames wrap.
    always_comb begin
        if (!resync && (state_q == ST_WAIT_SWAP) && word_evt_s && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end else begin
            drop_d = drop_q;
        end
        if ((state_q == ST_WAIT_SWAP) && scan_frame_end) begin
            frame_d = frame_q + 16'd1;
        end else begin
            frame_d = frame_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_q  <= 16'd0;
            frame_q <= 16'd0;
        end else begin
            drop_q  <= drop_d;
            frame_q <= frame_d;
        end
    end

    assign drop_count  = drop_q;
    assign frame_count = frame_q;
`else
    assign drop_count  = 16'd0;
    assign frame_count = 16'd0;
`endif

    assign fb_we        = fb_we_q;
    assign fb_waddr     = fb_waddr_q;
    assign fb_wdata     = fb_wdata_q;
    assign display_bank = bank_q;
    assign swap_pending = pend_q;
    assign overflow     = ovf_q;

endmodule

// File: tb/tb_pixel_write_sequencer.sv
// Bench for pixel_write_sequencer on a 4x2 panel: directed scenarios with literal
// expectations plus randomized traffic against a frame-level reference model.
module tb_pixel_write_sequencer;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;
`ifdef PIXEL_WRITE_SEQ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] spi_data = 32'd0;
    logic        spi_pixel_clk = 1'b0;
    logic        resync = 1'b0;
    logic        scan_frame_end = 1'b0;
    logic        fb_we;
    logic [3:0]  fb_waddr;
    logic [31:0] fb_wdata;
    logic        display_bank;
    logic        swap_pending;
    logic        overflow;
    logic [15:0] drop_count;
    logic [15:0] frame_count;

    int n_checks = 0;
    int n_pass   = 0;
    bit rand_phase = 1'b0;

    pixel_write_sequencer #(
        .BITS_PER_PIXEL (32),
        .PANEL_WIDTH    (W),
        .PANEL_HEIGHT   (H)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .spi_data       (spi_data),
        .spi_pixel_clk  (spi_pixel_clk),
        .resync         (resync),
        .scan_frame_end (scan_frame_end),
        .fb_we          (fb_we),
        .fb_waddr       (fb_waddr),
        .fb_wdata       (fb_wdata),
        .display_bank   (display_bank),
        .swap_pending   (swap_pending),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .frame_count    (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level reference: pixel index p within the back bank, plus a strobe-to-write delay line.
    typedef struct packed {
        int          p;
        logic        bank;
        logic        pend;
        logic        ovf;
        int          drop;
        int          frame;
        logic        we;
        logic [3:0]  addr;
        logic [31:0] data;
        logic        sprev;
        logic        pipe0;
        logic        pipe1;
        logic [31:0] d0;
        logic [31:0] d1;
    } model_t;

    model_t m;

    function automatic model_t model_step(input model_t s, input logic strobe, input logic [31:0] d,
                                          input logic rs, input logic sfe);
        model_t n;
        n    = s;
        n.we = 1'b0;
        if (rs) begin
            n.p = 0;
        end else if (s.pipe1) begin
            if (!s.pend) begin
                n.we   = 1'b1;
                n.addr = 4'((s.bank ? 0 : NPIX) + s.p);
                n.data = s.d1;
                n.p    = s.p + 1;
                if (n.p == NPIX) begin
                    n.p    = 0;
                    n.pend = 1'b1;
                end
            end else begin
                n.ovf = 1'b1;
                if (s.drop < 65535) n.drop = s.drop + 1;
            end
        end
        if (s.pend && sfe) begin
            n.bank  = ~s.bank;
            n.pend  = 1'b0;
            n.frame = (s.frame + 1) % 65536;
        end
        n.pipe1 = s.pipe0;
        n.d1    = s.d0;
        n.pipe0 = strobe & ~s.sprev;
        n.d0    = d;
        n.sprev = strobe;
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m <= '0;
        else          m <= model_step(m, spi_pixel_clk, spi_data, resync, scan_frame_end);
    end

    always @(negedge clk) begin
        check("m_fb_we", {31'd0, fb_we}, {31'd0, m.we});
        if (m.we) begin
            check("m_fb_waddr", {28'd0, fb_waddr}, {28'd0, m.addr});
            check("m_fb_wdata", fb_wdata, m.data);
        end
        check("m_display_bank", {31'd0, display_bank}, {31'd0, m.bank});
        check("m_swap_pending", {31'd0, swap_pending}, {31'd0, m.pend});
        check("m_overflow", {31'd0, overflow}, {31'd0, m.ovf});
        check("m_drop_count", {16'd0, drop_count}, STATS ? 32'(m.drop) : 32'd0);
        check("m_frame_count", {16'd0, frame_count}, STATS ? 32'(m.frame) : 32'd0);
    end

    task automatic pulse(input bit is_sfe);
        @(posedge clk); #3;
        if (is_sfe) scan_frame_end = 1'b1; else resync = 1'b1;
        @(posedge clk); #3;
        scan_frame_end = 1'b0;
        resync = 1'b0;
    endtask

    // One strobe; fb_we must show at the 4th negedge after the rise (3rd cycle after first sample).
    task automatic send_word(input logic [31:0] d, input bit exp_we, input logic [3:0] exp_addr,
                             input bit with_resync, input bit with_sfe);
        int seen_at;
        seen_at  = 0;
        spi_data = d;
        @(posedge clk); #3;
        spi_pixel_clk = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 3) begin
                resync         = with_resync;
                scan_frame_end = with_sfe;
            end
            if (k == 4) begin
                resync         = 1'b0;
                scan_frame_end = 1'b0;
            end
            if (fb_we && seen_at == 0) begin
                seen_at = k;
                if (exp_we) begin
                    check("d_waddr", {28'd0, fb_waddr}, {28'd0, exp_addr});
                    check("d_wdata", fb_wdata, d);
                end
            end
        end
        spi_pixel_clk = 1'b0;
        if (exp_we) check("d_write_latency", seen_at, 4);
        else        check("d_no_write", seen_at, 0);
        repeat (4) @(posedge clk);
    endtask

    task automatic check_all_zero(input string nm);
        check(nm, {fb_we, display_bank, swap_pending, overflow, fb_waddr, 24'd0}, 32'd0);
        check({nm, "_data"}, fb_wdata, 32'd0);
        check({nm, "_stats"}, {drop_count, frame_count}, 32'd0);
    endtask

    // Randomized resync / scan_frame_end pulses while random traffic runs.
    initial begin
        forever begin
            @(posedge clk); #3;
            if (rand_phase) begin
                resync         = ($urandom_range(0, 99) < 3);
                scan_frame_end = ($urandom_range(0, 99) < 10);
            end
        end
    end

    initial begin
        #23;
        check_all_zero("reset_state");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 1; i <= 8; i++) send_word(32'(i), 1'b1, 4'(7 + i), 1'b0, 1'b0);
        check("swap_pending_after_8", {31'd0, swap_pending}, 32'd1);
        check("bank_before_swap", {31'd0, display_bank}, 32'd0);

        send_word(32'h9, 1'b0, 4'd0, 1'b0, 1'b0);
        check("overflow_after_drop", {31'd0, overflow}, 32'd1);
        check("drop_count_1", {16'd0, drop_count}, STATS ? 32'd1 : 32'd0);

        pulse(1'b1);
        @(negedge clk);
        check("bank_after_swap", {31'd0, display_bank}, 32'd1);
        check("pending_after_swap", {31'd0, swap_pending}, 32'd0);
        check("frame_count_1", {16'd0, frame_count}, STATS ? 32'd1 : 32'd0);
        send_word(32'hA, 1'b1, 4'd0, 1'b0, 1'b0);

        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        reset_n = 1'b1;

        send_word(32'h11, 1'b1, 4'd8, 1'b0, 1'b0);
        send_word(32'h12, 1'b1, 4'd9, 1'b0, 1'b0);
        send_word(32'h13, 1'b1, 4'd10, 1'b0, 1'b0);
        pulse(1'b0);
        send_word(32'h14, 1'b1, 4'd8, 1'b0, 1'b0);
        send_word(32'h15, 1'b0, 4'd0, 1'b1, 1'b0);
        send_word(32'h16, 1'b1, 4'd8, 1'b0, 1'b0);

        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 7; i++) send_word(32'h20 + 32'(i), 1'b1, 4'(8 + i), 1'b0, 1'b0);
        send_word(32'h27, 1'b1, 4'd15, 1'b0, 1'b1);
        check("coincident_bank", {31'd0, display_bank}, 32'd0);
        check("coincident_pending", {31'd0, swap_pending}, 32'd1);
        pulse(1'b1);
        @(negedge clk);
        check("bank_after_late_swap", {31'd0, display_bank}, 32'd1);

        rand_phase = 1'b1;
        for (int i = 0; i < 200; i++) begin
            spi_data = $urandom;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1 spi_pixel_clk = 1'b1;
            repeat ($urandom_range(3, 5)) @(posedge clk);
            #1 spi_pixel_clk = 1'b0;
            repeat ($urandom_range(3, 5)) @(posedge clk);
            if (i == 120) begin
                #2 reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
            end
        end
        rand_phase = 1'b0;
        repeat (8) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
